// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types, port indices and helpers for the SRAM arbiter
package sram_arb_pkg;
  typedef enum logic {S_ARB_IDLE, S_ARB_LOCKED} arb_state_type;
  localparam logic [1:0] PORT_VGA = 2'd0;
  localparam logic [1:0] PORT_UART = 2'd1;
  localparam logic [1:0] PORT_DEC = 2'd2;
  localparam logic [1:0] OWNER_NONE = 2'd3;
  function automatic logic [1:0] other_port(input logic [1:0] p);
    return p == PORT_UART ? PORT_DEC : PORT_UART;
  endfunction
endpackage

// File: rtl/sram_read_tag_pipe.sv
// sram_read_tag_pipe: READ_LATENCY-deep {valid, port} shift register decoding to one-hot rd_valid
module sram_read_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_valid_i,
  input  logic [1:0] push_port_i,
  output logic [2:0] rd_valid_o
);
  logic [2:0] tag_q [READ_LATENCY];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= {push_valid_i, push_port_i};
      for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end
  always_comb rd_valid_o = tag_q[READ_LATENCY-1][2] ? 3'(3'b001 << tag_q[READ_LATENCY-1][1:0]) : 3'b000;
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: three-port SRAM access arbiter with fixed VGA priority, round-robin, burst lock and read tagging
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int READ_LATENCY = 2,
  parameter int MAX_HOLD = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [2:0]             req_i,
  input  logic [2:0]             lock_i,
  input  logic [2:0]             we_n_i,
  input  logic [2:0][ADDR_W-1:0] addr_i,
  input  logic [2:0][DATA_W-1:0] wdata_i,
  output logic [2:0]             ack_o,
  output logic [2:0]             rd_valid_o,
  output logic [DATA_W-1:0]      rd_data_o,
  output logic [ADDR_W-1:0]      SRAM_address_o,
  output logic [DATA_W-1:0]      SRAM_write_data_o,
  output logic                   SRAM_we_n_o,
  input  logic [DATA_W-1:0]      SRAM_read_data_i,
  output logic [1:0]             owner_o
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  arb_state_type state_q, state_d;
  logic [1:0] rr_next_q, rr_next_d, owner_q, owner_d, win, rr_win;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
  logic [3:0] req_x, lock_x;
  logic win_vld, held, push_valid;
  always_comb begin
    req_x = rst_i ? 4'b0000 : {1'b0, req_i};
    lock_x = {1'b0, lock_i};
    held = state_q == S_ARB_LOCKED && req_x[owner_q] && lock_x[owner_q];
    rr_win = req_x[rr_next_q] ? rr_next_q : req_x[other_port(rr_next_q)] ? other_port(rr_next_q) : OWNER_NONE;
    win = req_x[PORT_VGA] ? PORT_VGA : held ? owner_q : rr_win;
    win_vld = win != OWNER_NONE;
    hold_inc = hold_cnt_q + HW'(1);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_ARB_IDLE;
      rr_next_q <= PORT_UART;
      owner_q <= OWNER_NONE;
      hold_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_next_q <= rr_next_d;
      owner_q <= owner_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    rr_next_d = rr_next_q;
    owner_d = owner_q;
    hold_cnt_d = hold_cnt_q;
    if (held) begin
      if (win == owner_q) begin
        rr_next_d = other_port(owner_q);
        hold_cnt_d = hold_inc;
        if (hold_inc == HW'(MAX_HOLD)) begin
          state_d = S_ARB_IDLE;
          owner_d = OWNER_NONE;
          hold_cnt_d = '0;
        end
      end
    end else begin
      rr_next_d = win_vld && win != PORT_VGA ? other_port(win) : state_q == S_ARB_LOCKED ? other_port(owner_q) : rr_next_q;
      state_d = win_vld && win != PORT_VGA && lock_x[win] ? S_ARB_LOCKED : S_ARB_IDLE;
      owner_d = state_d == S_ARB_LOCKED ? win : OWNER_NONE;
      hold_cnt_d = state_d == S_ARB_LOCKED ? HW'(1) : '0;
    end
  end
  always_comb begin
    ack_o = win_vld ? 3'(3'b001 << win) : 3'b000;
    SRAM_address_o = win_vld ? addr_i[win] : '0;
    SRAM_write_data_o = win_vld ? wdata_i[win] : '0;
    SRAM_we_n_o = win_vld ? we_n_i[win] : 1'b1;
    push_valid = win_vld && we_n_i[win];
    owner_o = owner_q;
    rd_data_o = SRAM_read_data_i;
  end
  sram_read_tag_pipe #(.READ_LATENCY(READ_LATENCY)) u_tag (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push_valid_i(push_valid),
    .push_port_i(win),
    .rd_valid_o(rd_valid_o)
  );
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed self-checking bench for sram_arbiter
module tb_sram_arbiter;
  logic clk, rst;
  logic [2:0] req, lock, we_n, ack, rd_valid;
  logic [2:0][17:0] addr;
  logic [2:0][15:0] wdata;
  logic [15:0] rd_data, sram_wdata, sram_rdata;
  logic [17:0] sram_addr, a1, a2;
  logic sram_we_n;
  logic [1:0] owner;
  int nchk, nerr;
  sram_arbiter #(.ADDR_W(18), .DATA_W(16), .READ_LATENCY(2), .MAX_HOLD(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_i(req),
    .lock_i(lock),
    .we_n_i(we_n),
    .addr_i(addr),
    .wdata_i(wdata),
    .ack_o(ack),
    .rd_valid_o(rd_valid),
    .rd_data_o(rd_data),
    .SRAM_address_o(sram_addr),
    .SRAM_write_data_o(sram_wdata),
    .SRAM_we_n_o(sram_we_n),
    .SRAM_read_data_i(sram_rdata),
    .owner_o(owner)
  );
  always #10 clk = ~clk;
  always_ff @(posedge clk) begin
    a1 <= sram_addr;
    a2 <= a1;
  end
  assign sram_rdata = a2[15:0] ^ 16'h5A5A;
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    req = 3'b000;
    lock = 3'b000;
    we_n = 3'b111;
    repeat (n) next_cycle();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    req = 3'b111;
    lock = 3'b000;
    we_n = 3'b111;
    addr[0] = 18'h00AAA;
    addr[1] = 18'h00200;
    addr[2] = 18'h00100;
    wdata = '0;
    repeat (2) begin
      @(negedge clk);
      nchk++;
      if (ack !== 3'b000) begin nerr++; $display("FAIL reset_ack: got %b want 000", ack); end
      nchk++;
      if (sram_we_n !== 1'b1) begin nerr++; $display("FAIL reset_we_n: got %b want 1", sram_we_n); end
    end
    nchk++;
    if (sram_addr !== 18'h0) begin nerr++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
    nchk++;
    if (owner !== 2'd3) begin nerr++; $display("FAIL reset_owner: got %0d want 3", owner); end
    nchk++;
    if (rd_valid !== 3'b000) begin nerr++; $display("FAIL reset_rd_valid: got %b want 000", rd_valid); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    nchk++;
    if (ack !== 3'b001) begin nerr++; $display("FAIL post_reset_ack: got %b want 001", ack); end
    nchk++;
    if (sram_addr !== 18'h00AAA) begin nerr++; $display("FAIL post_reset_addr: got %h want 00aaa", sram_addr); end
    next_cycle();
    idle(3);
  endtask
  task automatic test_round_robin();
    logic [2:0] exp_ack [4] = '{3'b010, 3'b100, 3'b010, 3'b100};
    req = 3'b110;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nchk++;
      if (ack !== exp_ack[i]) begin nerr++; $display("FAIL rr_ack[%0d]: got %b want %b", i, ack, exp_ack[i]); end
      next_cycle();
    end
    idle(3);
  endtask
  task automatic test_read_tag();
    logic [2:0] exp_ack [5] = '{3'b100, 3'b010, 3'b000, 3'b000, 3'b000};
    logic [2:0] exp_rv [5] = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b000};
    logic [15:0] exp_rd [5] = '{16'h0, 16'h0, 16'h5B5A, 16'h585A, 16'h0};
    addr[2] = 18'h00100;
    addr[1] = 18'h00200;
    for (int i = 0; i < 5; i++) begin
      req = i == 0 ? 3'b100 : i == 1 ? 3'b010 : 3'b000;
      @(negedge clk);
      nchk++;
      if (ack !== exp_ack[i]) begin nerr++; $display("FAIL tag_ack[%0d]: got %b want %b", i, ack, exp_ack[i]); end
      nchk++;
      if (rd_valid !== exp_rv[i]) begin nerr++; $display("FAIL tag_rd_valid[%0d]: got %b want %b", i, rd_valid, exp_rv[i]); end
      if (i == 2 || i == 3) begin
        nchk++;
        if (rd_data !== exp_rd[i]) begin nerr++; $display("FAIL tag_rd_data[%0d]: got %h want %h", i, rd_data, exp_rd[i]); end
      end
      next_cycle();
    end
    idle(2);
  endtask
  task automatic test_lock_burst();
    logic [2:0] t_req [6] = '{3'b010, 3'b110, 3'b110, 3'b110, 3'b110, 3'b000};
    logic [2:0] t_lock [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
    logic [2:0] exp_ack [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b000};
    logic [1:0] exp_own [6] = '{2'd3, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3};
    for (int i = 0; i < 6; i++) begin
      req = t_req[i];
      lock = t_lock[i];
      @(negedge clk);
      nchk++;
      if (ack !== exp_ack[i]) begin nerr++; $display("FAIL burst_ack[%0d]: got %b want %b", i, ack, exp_ack[i]); end
      nchk++;
      if (owner !== exp_own[i]) begin nerr++; $display("FAIL burst_owner[%0d]: got %0d want %0d", i, owner, exp_own[i]); end
      next_cycle();
    end
    idle(2);
  endtask
  task automatic test_preempt();
    logic [2:0] t_req [11] = '{3'b010, 3'b111, 3'b111, 3'b110, 3'b110, 3'b110, 3'b100, 3'b010, 3'b011, 3'b110, 3'b000};
    logic [2:0] t_lock [11] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000};
    logic [2:0] exp_ack [11] = '{3'b010, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b100, 3'b010, 3'b001, 3'b100, 3'b000};
    logic [1:0] exp_own [11] = '{2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3, 2'd3};
    for (int i = 0; i < 11; i++) begin
      req = t_req[i];
      lock = t_lock[i];
      @(negedge clk);
      nchk++;
      if (ack !== exp_ack[i]) begin nerr++; $display("FAIL preempt_ack[%0d]: got %b want %b", i, ack, exp_ack[i]); end
      nchk++;
      if (owner !== exp_own[i]) begin nerr++; $display("FAIL preempt_owner[%0d]: got %0d want %0d", i, owner, exp_own[i]); end
      next_cycle();
    end
    idle(2);
  endtask
  task automatic test_write_and_reset();
    addr[2] = 18'h00300;
    wdata[2] = 16'hBEEF;
    req = 3'b100;
    we_n = 3'b011;
    @(negedge clk);
    nchk++;
    if (ack !== 3'b100) begin nerr++; $display("FAIL wr_ack: got %b want 100", ack); end
    nchk++;
    if (sram_we_n !== 1'b0) begin nerr++; $display("FAIL wr_we_n: got %b want 0", sram_we_n); end
    nchk++;
    if (sram_wdata !== 16'hBEEF) begin nerr++; $display("FAIL wr_data: got %h want beef", sram_wdata); end
    nchk++;
    if (sram_addr !== 18'h00300) begin nerr++; $display("FAIL wr_addr: got %h want 00300", sram_addr); end
    next_cycle();
    req = 3'b000;
    we_n = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nchk++;
      if (sram_we_n !== 1'b1) begin nerr++; $display("FAIL wr_after_we_n[%0d]: got %b want 1", i, sram_we_n); end
      nchk++;
      if (rd_valid !== 3'b000) begin nerr++; $display("FAIL wr_rd_valid[%0d]: got %b want 000", i, rd_valid); end
      next_cycle();
    end
    req = 3'b010;
    @(negedge clk);
    nchk++;
    if (ack !== 3'b010) begin nerr++; $display("FAIL rst_rd_ack: got %b want 010", ack); end
    next_cycle();
    req = 3'b000;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nchk++;
      if (rd_valid !== 3'b000) begin nerr++; $display("FAIL rst_rd_valid[%0d]: got %b want 000", i, rd_valid); end
      next_cycle();
    end
  endtask
  initial begin
    clk = 1'b0;
    nchk = 0;
    nerr = 0;
    test_reset();
    test_round_robin();
    test_read_tag();
    test_lock_burst();
    test_preempt();
    test_write_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single SRAM_Controller port between three requesters: VGA fetch (port 0), UART loader (port 1) and decoder datapath (port 2).
- Replaces the top-level address/write-enable muxing driven by the top state machine.
- Provides per-port acknowledge, bus-lock for bursts, and read-data-valid tagging matched to the SRAM controller read latency.
- Sits between the requester units and SRAM_Controller inside the top module.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width.
- READ_LATENCY, 2, cycles from issued read address to valid SRAM_read_data (min 1, max 4).
- MAX_HOLD, 64, max acked accesses a locking owner gets before forced release (min 2).

Ports:
- Clock  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-high reset.
- req  in  3  per-port access request.
- lock  in  3  per-port burst lock, sampled with req.
- we_n  in  3  per-port write enable, active low.
- addr  in  3xADDR_W  per-port address.
- wdata  in  3xDATA_W  per-port write data.
- ack  out  3  one-hot; access of that port issued this cycle (combinational).
- rd_valid  out  3  one-hot; SRAM_read_data belongs to that port this cycle.
- rd_data  out  DATA_W  pass-through of SRAM_read_data.
- SRAM_address  out  ADDR_W  to SRAM_Controller.
- SRAM_write_data  out  DATA_W  to SRAM_Controller.
- SRAM_we_n  out  1  to SRAM_Controller.
- SRAM_read_data  in  DATA_W  from SRAM_Controller.
- owner  out  2  current lock owner (3 = none), for LEDs/debug.

Behaviour:
- Reset (sync, active-high, overrides everything):
  - state = S_ARB_IDLE, rr_next = port 1, hold_cnt = 0.
  - Tag pipeline cleared, owner = 3.
  - ack = 0, rd_valid = 0, SRAM_we_n = 1, SRAM_address = 0, SRAM_write_data = 0 (defaults while no ack).
- One access per cycle; winner's addr/wdata/we_n drive the SRAM outputs combinationally; ack of the winner is high in the same cycle.
- With no winner: SRAM_we_n = 1 and address/data hold 0. No spurious writes.
- Priority:
  - Port 0 (VGA) is fixed highest in every state and preempts a lock.
  - Ports 1/2 are round-robin via rr_next, which updates to the other port after each ack of 1 or 2.
- States:
  - S_ARB_IDLE: select the winner. If the winner is port 1 or 2 with lock = 1, go to S_ARB_LOCKED with owner = winner and hold_cnt = 1. A lock on port 0 is ignored.
  - S_ARB_LOCKED:
    - Owner gets every cycle that port 0 does not request; the non-owner of ports 1/2 never wins.
    - If port 0 requests, it is acked and the owner is stalled (ack = 0). Lock is retained and hold_cnt is unchanged.
    - hold_cnt increments on each owner ack.
    - Exit to S_ARB_IDLE when the owner deasserts lock or req (that cycle is arbitrated as in IDLE), or after the owner ack that makes hold_cnt == MAX_HOLD.
    - On any exit, rr_next = the non-owner, owner = 3, hold_cnt = 0.
- Read tagging:
  - Each acked read (we_n = 0 not set) pushes {valid, port} into a READ_LATENCY-deep shift register.
  - At the tail, rd_valid[port] = 1 exactly READ_LATENCY cycles after the ack.
  - Writes push valid = 0. Back-to-back reads from mixed ports keep issue order.
- Reset mid-operation: in-flight tags are discarded; no rd_valid after reset is asserted.
- Simultaneous req 1 and 2 in IDLE: the rr_next port wins.
- Simultaneous lock release and port 0 request: port 0 wins and the state returns to IDLE.

Decomposition:
- Package sram_arb_pkg:
  - arb_state_type enum {S_ARB_IDLE, S_ARB_LOCKED}.
  - Port index constants PORT_VGA = 0, PORT_UART = 1, PORT_DEC = 2.
  - OWNER_NONE = 3.
- Sub-module sram_read_tag_pipe: parameterised READ_LATENCY shift register of {valid, port[1:0]} that decodes to rd_valid.

Test Plan:
- Reset with req = 3'b111 held → ack = 0, SRAM_we_n = 1 during reset. First cycle after: ack = 3'b001, SRAM_address = addr[0].
- Port 1 and 2 request continuously, no lock → acks alternate 1, 2, 1, 2 starting with port 1. No consecutive repeats.
- Port 2 reads at 0x00100 (ack cycle t), then port 1 reads 0x00200 at t+1 → rd_valid = 3'b100 at t+2, rd_valid = 3'b010 at t+3, with rd_data equal to the model SRAM contents.
- Port 1 locks with req continuous, MAX_HOLD = 4, port 2 requesting → four port-1 acks, then port 2 acked. owner = 1 during the burst and 3 afterwards.
- Port 1 locked, port 0 requests for 2 cycles mid-burst → port 0 acked twice, port 1 stalled, lock kept, hold_cnt unchanged, burst resumes.
- Port 2 write (we_n = 0, wdata = 0xBEEF) → SRAM_we_n = 0 for one cycle and no rd_valid. A read issued before a mid-flight Reset yields no rd_valid.
